mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ES_TO_MS_BUS_WD, default 71, width of the EXE-to-MEM bus.
REQ-002 SHALL have parameter MS_TO_WS_BUS_WD, default 70, width of the MEM-to-WB bus.
REQ-003 SHALL have port: clk  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port: resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port: ws_allowin  in  1  WB stage can accept this cycle.
REQ-006 SHALL have port: ms_allowin  out  1  MEM can accept from EXE this cycle.
REQ-007 SHALL have port: es_to_ms_valid  in  1  EXE offers an instruction.
REQ-008 SHALL have port: es_to_ms_bus  in  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-009 SHALL have port: data_sram_rdata  in  32  synchronous SRAM read data, valid one cycle after the EXE-stage address.
REQ-010 SHALL have port: ms_to_ws_valid  out  1  MEM offers an instruction to WB.
REQ-011 SHALL have port: ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-012 SHALL have port: ms_fwd_bus  out  39  {fwd_valid[38], is_load[37], dest[36:32], final_result[31:0]} to decode bypass/hazard logic.

Function
REQ-013 SHALL hold one instruction in register ms_valid plus latched bus ms_bus_r (71 b).
REQ-014 SHALL set ms_ready_go = 1 always, with no internal stall source.
REQ-015 SHALL drive ms_allowin = !ms_valid || (ms_ready_go && ws_allowin), combinationally.
REQ-016 SHALL drive ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-017 SHALL update ms_valid <= es_to_ms_valid when ms_allowin = 1, and otherwise hold it.
REQ-018 SHALL latch ms_bus_r <= es_to_ms_bus only when es_to_ms_valid && ms_allowin, and otherwise hold it.
REQ-019 SHALL keep first-cycle flag ms_first, set to 1 on the cycle after a latch per REQ-018 and to 0 on every other cycle.
REQ-020 SHALL provide load-data buffer rdata_buf (32 b) and rdata_buf_valid (1 b), so that load data survives a WB stall once the SRAM output has moved on.
REQ-021 SHALL, when ms_valid && ms_first && res_from_mem && !ws_allowin, capture rdata_buf <= data_sram_rdata and set rdata_buf_valid <= 1.
REQ-022 SHALL clear rdata_buf_valid when the held instruction leaves (ms_valid && ws_allowin) or a new one is latched, with the clear taking priority over capture only for a new latch.
REQ-023 SHALL form mem_result = rdata_buf_valid ? rdata_buf : data_sram_rdata.
REQ-024 SHALL form final_result = res_from_mem ? mem_result : alu_result, using full 32-bit words with no byte or halfword extraction.
REQ-025 SHALL drive ms_to_ws_bus = {gr_we, dest, final_result, pc} from ms_bus_r, with fields as in REQ-011.
REQ-026 SHALL drive fwd_valid = ms_valid && gr_we && (dest != 0), and is_load = ms_valid && res_from_mem.
REQ-027 SHALL drive the ms_fwd_bus dest and final_result fields exactly as in ms_to_ws_bus, even when fwd_valid = 0.
REQ-028 SHALL, on simultaneous departure and arrival (ms_valid, ws_allowin, es_to_ms_valid all 1), replace the instruction in the same cycle with no bubble.
REQ-029 SHALL, when ms_valid = 0, ignore data_sram_rdata, leaving rdata_buf unchanged.
REQ-030 SHALL present the latency of an instruction through the stage as exactly 1 cycle when ws_allowin = 1.

Reset
REQ-031 SHALL, on a clock edge with resetn = 0, clear ms_valid, ms_first, rdata_buf_valid, rdata_buf and ms_bus_r to 0.
REQ-032 SHALL hold these post-reset outputs: ms_allowin = 1, ms_to_ws_valid = 0, ms_to_ws_bus = 0, ms_fwd_bus = 0.
REQ-033 SHALL, when reset is applied mid-operation, discard the held instruction and any buffered load data; es_to_ms_valid is ignored while resetn = 0.

Verification
REQ-034 SHALL have directed scenario ALU pass-through: bus {0,1,5'd3,32'h1234_5678,32'hBFC0_0010}, ws_allowin = 1 -> next cycle ms_to_ws_valid = 1, ms_to_ws_bus = {1,3,32'h1234_5678,32'hBFC0_0010}, fwd_valid = 1.
REQ-035 SHALL have directed scenario load no stall: res_from_mem = 1, dest = 8, rdata = 32'hDEAD_BEEF in the first MS cycle -> final_result = 32'hDEAD_BEEF, is_load = 1.
REQ-036 SHALL have directed scenario load with 3-cycle WB stall: rdata = 32'hDEAD_BEEF in the first cycle then 32'h0 -> final_result stays 32'hDEAD_BEEF all 4 cycles, ms_allowin = 0 for 3 cycles, and rdata_buf_valid = 0 after departure.
REQ-037 SHALL have directed scenario back-to-back streaming: 4 consecutive valid instructions with ws_allowin = 1 -> 4 consecutive ms_to_ws_valid cycles, no bubbles, PCs in order.
REQ-038 SHALL have directed scenario dest 0: gr_we = 1, dest = 0 -> fwd_valid = 0 while ms_to_ws_valid = 1.
REQ-039 SHALL have directed scenario reset mid-stall: load held with ws_allowin = 0, resetn = 0 for one edge -> ms_to_ws_valid = 0, ms_allowin = 1, ms_fwd_bus = 0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of a five-stage pipeline: holds one instruction, merges synchronous
// SRAM load data with the ALU result, and keeps load data alive across WB stalls.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [38:0]                ms_fwd_bus
);

  // Handshake: an instruction moves across a boundary on a posedge where the sender's
  // valid and the receiver's allowin are both 1; allowin never depends on the sender's valid.
  logic                       ms_valid;
  logic                       ms_first;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_buf_valid;
  logic                       ms_ready_go;
  logic                       latch;
  logic                       capture;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_result;
  logic [31:0] final_result;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign latch          = es_to_ms_valid && ms_allowin;

  // SRAM data is only valid in the first MEM cycle; grab it if WB is not taking us then.
  assign capture = ms_valid && ms_first && res_from_mem && !ws_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_first <= 1'b0;
      ms_bus_r <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (latch) begin
        ms_bus_r <= es_to_ms_bus;
      end
      ms_first <= latch;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_buf       <= 32'd0;
      rdata_buf_valid <= 1'b0;
    end else if (latch) begin
      rdata_buf_valid <= 1'b0;
    end else if (capture) begin
      rdata_buf       <= data_sram_rdata;
      rdata_buf_valid <= 1'b1;
    end else if (ms_valid && ws_allowin) begin
      rdata_buf_valid <= 1'b0;
    end
  end

  assign res_from_mem = ms_bus_r[70];
  assign gr_we        = ms_bus_r[69];
  assign dest         = ms_bus_r[68:64];
  assign alu_result   = ms_bus_r[63:32];
  assign pc           = ms_bus_r[31:0];

  assign mem_result   = rdata_buf_valid ? rdata_buf : data_sram_rdata;
  assign final_result = res_from_mem ? mem_result : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid && gr_we && (dest != 5'd0),
                         ms_valid && res_from_mem,
                         dest,
                         final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle vector table for streaming traffic,
// plus hand-written sequences for WB stall on a load and reset during a stall.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_fwd_bus;

  int n_cmp;
  int n_err;

  mem_stage #(
    .ES_TO_MS_BUS_WD(71),
    .MS_TO_WS_BUS_WD(70)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_fwd_bus     (ms_fwd_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        es_valid;
    logic [70:0] es_bus;
    logic [31:0] rdata;
    logic        ws_allow;
    logic        exp_valid;
    logic        exp_allowin;
    logic [69:0] exp_bus;
    logic [38:0] exp_fwd;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [70:0] mk_es(input logic res, input logic we, input logic [4:0] d,
                                        input logic [31:0] alu, input logic [31:0] p);
    return {res, we, d, alu, p};
  endfunction

  function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] d,
                                        input logic [31:0] r, input logic [31:0] p);
    return {we, d, r, p};
  endfunction

  function automatic logic [38:0] mk_fwd(input logic fv, input logic ld, input logic [4:0] d,
                                         input logic [31:0] r);
    return {fv, ld, d, r};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic ev, input logic [70:0] eb, input logic [31:0] rd,
                         input logic wa, input logic xv, input logic xa, input logic [69:0] xb,
                         input logic [38:0] xf);
    vecs[i].es_valid    = ev;
    vecs[i].es_bus      = eb;
    vecs[i].rdata       = rd;
    vecs[i].ws_allow    = wa;
    vecs[i].exp_valid   = xv;
    vecs[i].exp_allowin = xa;
    vecs[i].exp_bus     = xb;
    vecs[i].exp_fwd     = xf;
  endtask

  // one cycle: drive after posedge, check on negedge, advance to next posedge
  task automatic drive(input logic ev, input logic [70:0] eb, input logic [31:0] rd, input logic wa);
    es_to_ms_valid  = ev;
    es_to_ms_bus    = eb;
    data_sram_rdata = rd;
    ws_allowin      = wa;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    drive(1'b1, mk_es(1'b0, 1'b1, 5'd7, 32'h5555_AAAA, 32'hBFC0_0000), 32'h0, 1'b1);

    // each row: inputs held for one cycle, outputs expected during that cycle
    set_vec(0, 1, mk_es(0, 1, 5'd3, 32'h1234_5678, 32'hBFC0_0010), 32'h0, 1,
            0, 1, 70'd0, 39'd0);
    set_vec(1, 1, mk_es(1, 1, 5'd8, 32'h0000_0100, 32'hBFC0_0014), 32'h0, 1,
            1, 1, mk_ws(1, 5'd3, 32'h1234_5678, 32'hBFC0_0010), mk_fwd(1, 0, 5'd3, 32'h1234_5678));
    set_vec(2, 0, 71'd0, 32'hDEAD_BEEF, 1,
            1, 1, mk_ws(1, 5'd8, 32'hDEAD_BEEF, 32'hBFC0_0014), mk_fwd(1, 1, 5'd8, 32'hDEAD_BEEF));
    set_vec(3, 1, mk_es(0, 1, 5'd0, 32'hCAFE_F00D, 32'hBFC0_0018), 32'h0, 1,
            0, 1, mk_ws(1, 5'd8, 32'h0, 32'hBFC0_0014), mk_fwd(0, 0, 5'd8, 32'h0));
    set_vec(4, 0, 71'd0, 32'h0, 1,
            1, 1, mk_ws(1, 5'd0, 32'hCAFE_F00D, 32'hBFC0_0018), mk_fwd(0, 0, 5'd0, 32'hCAFE_F00D));
    set_vec(5, 1, mk_es(0, 1, 5'd1, 32'd1, 32'hBFC0_0020), 32'h0, 1,
            0, 1, mk_ws(1, 5'd0, 32'hCAFE_F00D, 32'hBFC0_0018), mk_fwd(0, 0, 5'd0, 32'hCAFE_F00D));
    set_vec(6, 1, mk_es(0, 1, 5'd2, 32'd2, 32'hBFC0_0024), 32'h0, 1,
            1, 1, mk_ws(1, 5'd1, 32'd1, 32'hBFC0_0020), mk_fwd(1, 0, 5'd1, 32'd1));
    set_vec(7, 1, mk_es(0, 1, 5'd3, 32'd3, 32'hBFC0_0028), 32'h0, 1,
            1, 1, mk_ws(1, 5'd2, 32'd2, 32'hBFC0_0024), mk_fwd(1, 0, 5'd2, 32'd2));
    set_vec(8, 1, mk_es(0, 1, 5'd4, 32'd4, 32'hBFC0_002C), 32'h0, 1,
            1, 1, mk_ws(1, 5'd3, 32'd3, 32'hBFC0_0028), mk_fwd(1, 0, 5'd3, 32'd3));
    set_vec(9, 0, 71'd0, 32'h0, 1,
            1, 1, mk_ws(1, 5'd4, 32'd4, 32'hBFC0_002C), mk_fwd(1, 0, 5'd4, 32'd4));
    set_vec(10, 0, 71'd0, 32'h0, 1,
            0, 1, mk_ws(1, 5'd4, 32'd4, 32'hBFC0_002C), mk_fwd(0, 0, 5'd4, 32'd4));

    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b0, 71'd0, 32'h0, 1'b1);
    @(negedge clk);
    check("reset ms_to_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    check("reset ms_allowin", {69'd0, ms_allowin}, 70'd1);
    check("reset ms_to_ws_bus", ms_to_ws_bus, 70'd0);
    check("reset ms_fwd_bus", {31'd0, ms_fwd_bus}, 70'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].es_valid, vecs[i].es_bus, vecs[i].rdata, vecs[i].ws_allow);
      @(negedge clk);
      check($sformatf("vec%0d valid", i), {69'd0, ms_to_ws_valid}, {69'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d allowin", i), {69'd0, ms_allowin}, {69'd0, vecs[i].exp_allowin});
      check($sformatf("vec%0d ws_bus", i), ms_to_ws_bus, vecs[i].exp_bus);
      check($sformatf("vec%0d fwd_bus", i), {31'd0, ms_fwd_bus}, {31'd0, vecs[i].exp_fwd});
      @(posedge clk);
      #1;
    end

    // load held for a 3-cycle WB stall; SRAM output moves on after the first cycle
    drive(1'b1, mk_es(1, 1, 5'd8, 32'h0000_0200, 32'hBFC0_0030), 32'h0, 1'b1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 71'd0, (c == 0) ? 32'hDEAD_BEEF : 32'h0, (c == 3));
      @(negedge clk);
      check($sformatf("stall%0d valid", c), {69'd0, ms_to_ws_valid}, 70'd1);
      check($sformatf("stall%0d allowin", c), {69'd0, ms_allowin}, {69'd0, (c == 3)});
      check($sformatf("stall%0d ws_bus", c), ms_to_ws_bus,
            mk_ws(1, 5'd8, 32'hDEAD_BEEF, 32'hBFC0_0030));
      check($sformatf("stall%0d fwd_bus", c), {31'd0, ms_fwd_bus},
            {31'd0, mk_fwd(1, 1, 5'd8, 32'hDEAD_BEEF)});
      @(posedge clk);
      #1;
    end
    // after departure the buffer is released, so the result follows the SRAM again
    drive(1'b0, 71'd0, 32'h1111_2222, 1'b1);
    @(negedge clk);
    check("post-stall valid", {69'd0, ms_to_ws_valid}, 70'd0);
    check("post-stall buf released", ms_to_ws_bus, mk_ws(1, 5'd8, 32'h1111_2222, 32'hBFC0_0030));
    @(posedge clk);
    #1;

    // reset while a load sits stalled with buffered data
    drive(1'b1, mk_es(1, 1, 5'd9, 32'h0, 32'hBFC0_0040), 32'h0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 71'd0, 32'hAAAA_5555, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 71'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("pre-reset held load", ms_to_ws_bus, mk_ws(1, 5'd9, 32'hAAAA_5555, 32'hBFC0_0040));
    @(posedge clk);
    #1;
    resetn = 1'b0;
    drive(1'b1, mk_es(0, 1, 5'd5, 32'h7777_7777, 32'hBFC0_0050), 32'h3333_3333, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b0, 71'd0, 32'h3333_3333, 1'b0);
    @(negedge clk);
    check("rst-stall valid", {69'd0, ms_to_ws_valid}, 70'd0);
    check("rst-stall allowin", {69'd0, ms_allowin}, 70'd1);
    check("rst-stall fwd_bus", {31'd0, ms_fwd_bus}, 70'd0);
    check("rst-stall ws_bus", ms_to_ws_bus, 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
